rgmii_rx_adapt: RTL and testbench
=================================

# rgmii_rx_adapt

Single-clock, speed-adaptive RGMII receive adapter. It sits directly after the RGMII DDR capture stage (IDDR pair per pin, SAME_EDGE_PIPELINED) in the receive clock domain. It turns the per-cycle rising/falling nibble pairs into a byte stream for 10/100/1000 Mb/s, with SFD-based nibble alignment, optional preamble stripping, end-of-frame marking on the last byte, error/length reporting and RGMII in-band link-status decoding.

## Interface
Parameters:
- P_STRIP_PREAMBLE, 1, 1 = drop preamble and SFD bytes; 0 = pass every byte while DV is high
- P_MAX_FRAME, 1522, frame length in bytes above which the frame is flagged as an error
- P_LEN_W, 16, width of the length counter and of o_rx_len

Ports:
- i_clk  in  1  recovered RGMII receive clock (125/25/2.5 MHz)
- i_rst  in  1  asynchronous, active-high reset
- i_speed  in  2  00 = 10M, 01 = 100M, 10 = 1000M; 11 is treated as 1000M
- i_ddr_data  in  8  [3:0] = rising-edge nibble, [7:4] = falling-edge nibble
- i_ddr_ctrl  in  2  [0] = rising (RX_DV), [1] = falling (RX_DV xor RX_ER)
- o_rx_data  out  8  received byte
- o_rx_valid  out  1  byte qualifier
- o_rx_last  out  1  marks the final byte of a frame
- o_rx_err  out  1  frame error, valid only with o_rx_last
- o_rx_len  out  P_LEN_W  count of output bytes in the frame, valid with o_rx_last
- o_false_carrier  out  1  one-cycle pulse
- o_link_up  out  1  in-band link status
- o_link_speed  out  2  in-band speed, same encoding as i_speed
- o_link_duplex  out  1  in-band duplex, 1 = full

## Operation
- Internal signals: dv = i_ddr_ctrl[0]; er = i_ddr_ctrl[0] ^ i_ddr_ctrl[1].
- The speed mode is latched from i_speed only in ST_IDLE. Changes to i_speed during a frame take effect at the next ST_IDLE.
- Byte assembly in 1000 mode: one byte per cycle, {i_ddr_data[7:4], i_ddr_data[3:0]}.
- Byte assembly in 10/100 mode: one nibble per cycle, taken from i_ddr_data[3:0]. The first nibble of a pair is the low nibble, the second is the high nibble, and a byte completes on the second.
- State machine:
  - ST_IDLE: on dv=1, go to ST_PRE if P_STRIP_PREAMBLE=1, otherwise go to ST_DATA. With P_STRIP_PREAMBLE=0 the nibble phase starts at this first dv cycle.
  - ST_PRE, 1000 mode: go to ST_DATA on byte 0xD5.
  - ST_PRE, nibble mode: go to ST_DATA on nibble 0xD following a 0x5 nibble. The next nibble is the low nibble of the first data byte, which realigns the phase. A leading odd preamble nibble is tolerated.
  - ST_PRE: if dv falls before the SFD, return to ST_IDLE with no output and no o_rx_last.
  - ST_DATA: each completed byte enters a one-byte hold register. The held byte is emitted when the next byte completes, or when dv falls. In the dv-fall case it is emitted with o_rx_last=1 and the state returns to ST_IDLE.
- Errors: a sticky frame error is set by any of:
  - er=1 in any dv cycle after leaving ST_IDLE;
  - an odd nibble count at dv fall (dribble nibble, which is discarded);
  - byte count > P_MAX_FRAME.
- The sticky error is reported on o_rx_err with o_rx_last and cleared on entry to ST_IDLE.
- Length: o_rx_len counts emitted bytes including the last one and saturates at all-ones.
- False carrier: in ST_IDLE with dv=0, er=1 and i_ddr_data[3:0]=0xE, o_false_carrier pulses for one cycle.
- In-band status: in ST_IDLE with dv=0 and er=0, the candidate is i_ddr_data[3:0] = {duplex, speed[1:0], link}.
  - The link outputs update only after two consecutive identical candidates.
  - Any other ctrl combination resets the match counter.

## Timing
- All outputs are registered.
- Reset values: every output is 0 (o_link_speed = 00); the state machine is in ST_IDLE; the hold register is empty.
- Latency: a byte that completes at edge k appears on the outputs after edge k+1. o_rx_last is asserted after the first edge at which dv=0 is sampled.
- o_rx_valid, o_rx_last and o_rx_err are single-cycle per byte. In nibble modes o_rx_valid is high at most every second cycle.
- No backpressure: the consumer must accept every valid cycle.
- Reset asserted mid-frame: all outputs are forced to 0 immediately, the frame is lost and no o_rx_last is generated.
- dv toggling back high in the cycle right after o_rx_last: a new frame starts normally with zero bubble.
- A one-byte frame (SFD, one byte, dv fall): a single beat with valid=1, last=1, len=1.

## Structure
- rgmii_pkg holds:
  - speed encodings SPD_10, SPD_100 and SPD_1000;
  - SFD_BYTE = 8'hD5, PRE_NIB = 4'h5, SFD_NIB = 4'hD, FC_NIB = 4'hE;
  - the state enum {ST_IDLE, ST_PRE, ST_DATA}.
- One sub-module, rgmii_inband_status, contains the candidate compare, the two-sample match counter and the link/speed/duplex registers.
- Everything else (nibble packer, SFD detect, hold stage, error and length logic) stays in the top module.

## Test plan
- 1000M, 7×0x55 + 0xD5 + bytes 01..40: 64 beats with data 01..40, last on 0x40, len=64, err=0, first beat two cycles after the first data byte.
- 100M, 15×5 + D nibbles, then 4 bytes AA BB CC DD sent low-nibble first: beats AA BB CC DD, valid every other cycle, last on DD, err=0.
- 10M, odd number of trailing nibbles (one extra nibble 0x3): the 4 full bytes are emitted, last on the 4th, err=1; the dribble nibble does not appear.
- 1000M, er=1 on byte 10 of 20: 20 beats, err=1 only on the last beat; 1600-byte frame with P_MAX_FRAME=1522: len=1600, err=1.
- Idle ctrl=00 with data 0xB for 1 cycle, then 0xB for 2 cycles: link outputs stay at 0 after the single cycle, then become up=1, speed=01, duplex=1. Idle ctrl=10 with data 0xE: one o_false_carrier pulse.
- i_rst pulse in the middle of a 1000M frame: all outputs are 0 during reset, no last is emitted, and the next full frame is received intact.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII receive adapter: speed codes, framing nibbles/bytes and FSM states.
package rgmii_pkg;

  localparam logic [1:0] SPD_10    = 2'b00;
  localparam logic [1:0] SPD_100   = 2'b01;
  localparam logic [1:0] SPD_1000  = 2'b10;

  localparam logic [7:0] SFD_BYTE  = 8'hD5;
  localparam logic [3:0] PRE_NIB   = 4'h5;
  localparam logic [3:0] SFD_NIB   = 4'hD;
  localparam logic [3:0] FC_NIB    = 4'hE;

  // Both DDR ctrl bits low: no DV and no error, i.e. normal inter-frame.
  localparam logic [1:0] CTRL_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA
  } state_t;

  // 11 is not a legal RGMII speed and is handled as gigabit.
  function automatic logic is_gig(input logic [1:0] spd);
    return !(spd == SPD_10 || spd == SPD_100);
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status decode: a candidate nibble is accepted after two identical idle samples.
module rgmii_inband_status
  import rgmii_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_idle,
  input  logic [1:0] i_ctrl,
  input  logic [3:0] i_nib,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_link_duplex
);

  logic [3:0] r_cand;
  logic       r_match_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cand        <= '0;
      r_match_cnt   <= 1'b0;
      o_link_up     <= 1'b0;
      o_link_speed  <= SPD_10;
      o_link_duplex <= 1'b0;
    end else if (i_idle && i_ctrl == CTRL_IDLE) begin
      r_cand      <= i_nib;
      r_match_cnt <= 1'b1;
      // candidate nibble layout: {duplex, speed[1:0], link}
      if (r_match_cnt && r_cand == i_nib) begin
        o_link_up     <= i_nib[0];
        o_link_speed  <= i_nib[2:1];
        o_link_duplex <= i_nib[3];
      end
    end else begin
      r_match_cnt <= 1'b0;
    end
  end

endmodule

// File: rtl/rgmii_rx_adapt.sv
// Speed-adaptive RGMII receive adapter: DDR nibble pairs in, framed byte stream with
// error/length reporting and in-band link status out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | inter-frame; speed latched, false carrier and in-band status
// ST_PRE  | inside preamble, hunting for the SFD
// ST_DATA | payload; bytes pass through a one-byte hold stage
module rgmii_rx_adapt
  import rgmii_pkg::*;
#(
  parameter bit P_STRIP_PREAMBLE = 1'b1,
  parameter int P_MAX_FRAME      = 1522,
  parameter int P_LEN_W          = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_speed,
  input  logic [7:0]         i_ddr_data,
  input  logic [1:0]         i_ddr_ctrl,
  output logic [7:0]         o_rx_data,
  output logic               o_rx_valid,
  output logic               o_rx_last,
  output logic               o_rx_err,
  output logic [P_LEN_W-1:0] o_rx_len,
  output logic               o_false_carrier,
  output logic               o_link_up,
  output logic [1:0]         o_link_speed,
  output logic               o_link_duplex
);

  state_t             r_state;
  logic [1:0]         r_mode;
  logic               r_phase;
  logic [3:0]         r_lo_nib;
  logic [3:0]         r_prev_nib;
  logic [7:0]         r_hold;
  logic               r_hold_v;
  logic               r_err;
  logic [P_LEN_W-1:0] r_len;

  logic               w_dv;
  logic               w_er;
  logic [3:0]         w_nib;
  logic               w_gig;
  logic               w_byte_done;
  logic [7:0]         w_byte;
  logic [P_LEN_W-1:0] w_len_inc;
  logic               w_over;
  logic               w_sfd;

  assign w_dv        = i_ddr_ctrl[0];
  assign w_er        = i_ddr_ctrl[0] ^ i_ddr_ctrl[1];
  assign w_nib       = i_ddr_data[3:0];
  // In idle the live speed input is used so a frame's first cycle already assembles correctly.
  assign w_gig       = is_gig((r_state == ST_IDLE) ? i_speed : r_mode);
  assign w_byte_done = w_dv && (w_gig || r_phase);
  assign w_byte      = w_gig ? i_ddr_data : {w_nib, r_lo_nib};
  assign w_len_inc   = (r_len == '1) ? r_len : r_len + 1'b1;
  assign w_over      = 32'(w_len_inc) > 32'(P_MAX_FRAME);
  assign w_sfd       = w_gig ? (i_ddr_data == SFD_BYTE)
                             : (r_prev_nib == PRE_NIB && w_nib == SFD_NIB);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_mode          <= SPD_1000;
      r_phase         <= 1'b0;
      r_lo_nib        <= '0;
      r_prev_nib      <= '0;
      r_hold          <= '0;
      r_hold_v        <= 1'b0;
      r_err           <= 1'b0;
      r_len           <= '0;
      o_rx_data       <= '0;
      o_rx_valid      <= 1'b0;
      o_rx_last       <= 1'b0;
      o_rx_err        <= 1'b0;
      o_rx_len        <= '0;
      o_false_carrier <= 1'b0;
    end else begin
      o_rx_valid      <= 1'b0;
      o_rx_last       <= 1'b0;
      o_rx_err        <= 1'b0;
      o_false_carrier <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mode          <= i_speed;
          r_phase         <= 1'b0;
          r_hold_v        <= 1'b0;
          r_err           <= 1'b0;
          r_len           <= '0;
          r_prev_nib      <= w_nib;
          o_false_carrier <= !w_dv && w_er && (w_nib == FC_NIB);
          if (w_dv) begin
            if (P_STRIP_PREAMBLE) begin
              r_state <= ST_PRE;
            end else begin
              r_state <= ST_DATA;
              if (w_gig) begin
                r_hold   <= i_ddr_data;
                r_hold_v <= 1'b1;
              end else begin
                r_lo_nib <= w_nib;
                r_phase  <= 1'b1;
              end
            end
          end
        end
        ST_PRE: begin
          r_prev_nib <= w_nib;
          if (!w_dv) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_er) r_err <= 1'b1;
            if (w_sfd) begin
              r_state <= ST_DATA;
              r_phase <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_dv) begin
            if (w_er) r_err <= 1'b1;
            if (!w_gig) begin
              r_phase <= !r_phase;
              if (!r_phase) r_lo_nib <= w_nib;
            end
            if (w_byte_done) begin
              r_hold   <= w_byte;
              r_hold_v <= 1'b1;
              if (r_hold_v) begin
                o_rx_valid <= 1'b1;
                o_rx_data  <= r_hold;
                o_rx_len   <= w_len_inc;
                r_len      <= w_len_inc;
                if (w_over) r_err <= 1'b1;
              end
            end
          end else begin
            r_state <= ST_IDLE;
            // A pending half byte at dv fall is a dribble nibble: dropped and flagged.
            if (r_hold_v) begin
              o_rx_valid <= 1'b1;
              o_rx_last  <= 1'b1;
              o_rx_data  <= r_hold;
              o_rx_len   <= w_len_inc;
              o_rx_err   <= r_err || r_phase || w_over;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rgmii_inband_status u_inband (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_idle        (r_state == ST_IDLE),
    .i_ctrl        (i_ddr_ctrl),
    .i_nib         (w_nib),
    .o_link_up     (o_link_up),
    .o_link_speed  (o_link_speed),
    .o_link_duplex (o_link_duplex)
  );

endmodule

// File: tb/tb_rgmii_rx_adapt.sv
// Self-checking bench for rgmii_rx_adapt: directed frames plus randomized frames against a
// frame-level expected-beat model.
module tb_rgmii_rx_adapt;

  localparam int MAX_FRAME = 1522;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_speed = 2'b10;
  logic [7:0]  i_ddr_data = 8'h00;
  logic [1:0]  i_ddr_ctrl = 2'b00;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        o_rx_last;
  logic        o_rx_err;
  logic [15:0] o_rx_len;
  logic        o_false_carrier;
  logic        o_link_up;
  logic [1:0]  o_link_speed;
  logic        o_link_duplex;

  rgmii_rx_adapt #(
    .P_STRIP_PREAMBLE (1'b1),
    .P_MAX_FRAME      (MAX_FRAME),
    .P_LEN_W          (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_speed         (i_speed),
    .i_ddr_data      (i_ddr_data),
    .i_ddr_ctrl      (i_ddr_ctrl),
    .o_rx_data       (o_rx_data),
    .o_rx_valid      (o_rx_valid),
    .o_rx_last       (o_rx_last),
    .o_rx_err        (o_rx_err),
    .o_rx_len        (o_rx_len),
    .o_false_carrier (o_false_carrier),
    .o_link_up       (o_link_up),
    .o_link_speed    (o_link_speed),
    .o_link_duplex   (o_link_duplex)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         err;
    int         len;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pl[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         abort_mode = 1'b0;
  bit         cur_nib = 1'b0;
  bit         want_first = 1'b0;
  int         prev_beat = -1;
  int         first_beat_cyc = 0;
  int         t_first_data = 0;
  int         fc_cnt = 0;
  logic [3:0] idle_nib = 4'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Inputs change 1 time unit after the rising edge; they are sampled at the next rising edge.
  task automatic drive(input logic [1:0] c, input logic [7:0] d);
    i_ddr_ctrl = c;
    i_ddr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero();
    check_val("zero_valid",  o_rx_valid, 0);
    check_val("zero_last",   o_rx_last, 0);
    check_val("zero_err",    o_rx_err, 0);
    check_val("zero_len",    o_rx_len, 0);
    check_val("zero_data",   o_rx_data, 0);
    check_val("zero_fc",     o_false_carrier, 0);
    check_val("zero_up",     o_link_up, 0);
    check_val("zero_speed",  o_link_speed, 0);
    check_val("zero_duplex", o_link_duplex, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check_val("drain_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Expected beats come from the frame description: every payload byte once, last on the
  // final one, error if any er during the frame, a dribble nibble, or an oversize frame.
  task automatic send_frame(input int spd, input int pre_n, input int er_at,
                            input bit dribble, input int n_idle);
    bit nib = (spd < 2);
    int n   = pl.size();
    bit err = (er_at >= 0) || (nib && dribble) || (n > MAX_FRAME);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d    = pl[i];
      b.last = (i == n - 1);
      b.err  = b.last && err;
      b.len  = (i + 1 > 65535) ? 65535 : i + 1;
      exp_q.push_back(b);
    end
    cur_nib = nib;
    i_speed = 2'(spd);
    if (!nib) begin
      for (int i = 0; i < pre_n; i++) begin
        drive(2'b11, 8'h55);
        i_speed = 2'($urandom_range(0, 3));
      end
      drive(2'b11, 8'hD5);
      for (int i = 0; i < n; i++) begin
        if (i == 0) t_first_data = cyc;
        drive((i == er_at) ? 2'b01 : 2'b11, pl[i]);
      end
    end else begin
      for (int i = 0; i < pre_n; i++) begin
        drive(2'b11, {4'($urandom), 4'h5});
        i_speed = 2'($urandom_range(0, 3));
      end
      drive(2'b11, {4'($urandom), 4'hD});
      for (int i = 0; i < n; i++) begin
        drive(2'b11, {4'($urandom), pl[i][3:0]});
        drive((i == er_at) ? 2'b01 : 2'b11, {4'($urandom), pl[i][7:4]});
      end
      if (dribble) drive(2'b11, {4'($urandom), 4'h3});
    end
    for (int i = 0; i < n_idle; i++) drive(2'b00, {4'h0, idle_nib});
  endtask

  always @(negedge clk) begin : mon
    beat_t e;
    if (o_false_carrier) fc_cnt++;
    if (abort_mode) begin
      check_val("abort_no_last", o_rx_last, 0);
    end else if (o_rx_valid) begin
      if (want_first) begin
        first_beat_cyc = cyc;
        want_first = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", o_rx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("beat_data", o_rx_data, e.d);
        check_val("beat_last", o_rx_last, e.last);
        check_val("beat_err", o_rx_err, e.err);
        if (e.last) begin
          check_val("beat_len", o_rx_len, e.len);
          prev_beat = -1;
        end else if (cur_nib) begin
          if (prev_beat >= 0) check_val("nib_gap", (cyc - prev_beat) >= 2, 1);
          prev_beat = cyc;
        end
      end
    end else if (o_rx_last) begin
      check_val("stray_last", o_rx_last, 0);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    i_rst = 1'b1;
    #1;
    check_all_zero();
    for (int i = 0; i < 3; i++) drive(2'b00, 8'h00);
    check_all_zero();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(2'b00, 8'h00);

    // in-band status: single candidate must not update, two consecutive must
    drive(2'b00, 8'h0B);
    check_val("ib_single_up", o_link_up, 0);
    check_val("ib_single_spd", o_link_speed, 0);
    drive(2'b10, 8'h00);
    drive(2'b00, 8'h0B);
    check_val("ib_first_up", o_link_up, 0);
    drive(2'b00, 8'h0B);
    check_val("ib_up", o_link_up, 1);
    check_val("ib_speed", o_link_speed, 2'b01);
    check_val("ib_duplex", o_link_duplex, 1);
    idle_nib = 4'hB;

    // false carrier pulse
    drive(2'b10, 8'h0E);
    check_val("fc_pulse", o_false_carrier, 1);
    drive(2'b00, {4'h0, idle_nib});
    check_val("fc_single", o_false_carrier, 0);
    check_val("fc_keeps_link", o_link_up, 1);
    drive(2'b00, {4'h0, idle_nib});

    // 1000M, 64 bytes 01..40 with first-beat latency
    pl.delete();
    for (int i = 1; i <= 64; i++) pl.push_back(8'(i));
    want_first = 1'b1;
    send_frame(2, 7, -1, 1'b0, 4);
    drain();
    check_val("first_latency", first_beat_cyc - t_first_data, 2);

    // 100M AA BB CC DD
    pl.delete();
    pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC); pl.push_back(8'hDD);
    send_frame(1, 15, -1, 1'b0, 4);
    drain();

    // 10M with a dribble nibble
    pl.delete();
    pl.push_back(8'h12); pl.push_back(8'h34); pl.push_back(8'h56); pl.push_back(8'h78);
    send_frame(0, 14, -1, 1'b1, 4);
    drain();

    // 1000M, er on byte 10 of 20
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    send_frame(3, 7, 9, 1'b0, 4);
    drain();

    // oversize 1600-byte frame
    pl.delete();
    for (int i = 0; i < 1600; i++) pl.push_back(8'($urandom));
    send_frame(2, 7, -1, 1'b0, 4);
    drain();

    // one-byte frames
    pl.delete();
    pl.push_back(8'h5A);
    send_frame(2, 3, -1, 1'b0, 3);
    drain();
    pl.delete();
    pl.push_back(8'hC3);
    send_frame(0, 7, -1, 1'b0, 3);
    drain();

    // dv falls inside the preamble: no beat at all
    i_speed = 2'b10;
    for (int i = 0; i < 5; i++) drive(2'b11, 8'h55);
    for (int i = 0; i < 4; i++) drive(2'b00, {4'h0, idle_nib});
    drain();

    // back-to-back frames separated by a single dv=0 cycle
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    send_frame(2, 7, -1, 1'b0, 1);
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    send_frame(2, 7, -1, 1'b0, 4);
    drain();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int spd   = $urandom_range(0, 3);
      int len   = $urandom_range(1, 48);
      bit nib   = (spd < 2);
      int er_at = -1;
      bit drib  = nib && ($urandom_range(0, 5) == 0);
      int pre   = nib ? $urandom_range(1, 15) : $urandom_range(1, 7);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      if ($urandom_range(0, 5) == 0) er_at = $urandom_range(0, len - 1);
      send_frame(spd, pre, er_at, drib, $urandom_range(1, 4));
    end
    drain();

    // reset in the middle of a 1000M frame
    abort_mode = 1'b1;
    i_speed = 2'b10;
    for (int i = 0; i < 7; i++) drive(2'b11, 8'h55);
    drive(2'b11, 8'hD5);
    for (int i = 0; i < 10; i++) drive(2'b11, 8'($urandom));
    i_rst = 1'b1;
    #1;
    check_all_zero();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 8'($urandom));
      check_val("rst_hold_valid", o_rx_valid, 0);
    end
    drive(2'b00, {4'h0, idle_nib});
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(2'b00, {4'h0, idle_nib});
    abort_mode = 1'b0;
    prev_beat = -1;
    exp_q.delete();
    pl.delete();
    for (int i = 0; i < 30; i++) pl.push_back(8'($urandom));
    send_frame(2, 7, -1, 1'b0, 4);
    drain();

    check_val("fc_total", fc_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
